// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared types, funct3 encodings and decode helpers for the load/store unit.
package ysyx_23060201_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 values with no meaning for the given direction (unsigned stores do not exist)
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_LB, F3_LH, F3_LW: bad = 1'b0;
      F3_LBU, F3_LHU:      bad = we;
      default:             bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Halfwords need even addresses, words need 4-byte alignment
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addr_lo[0];
      F3_LW:         mis = (addr_lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane strobe for a store; upper nibble is always zero
  function automatic logic [7:0] wmask_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] m;
    m = 4'b0000;
    case (funct3)
      F3_LB:   m = 4'b0001 << addr_lo;
      F3_LH:   m = 4'b0011 << addr_lo;
      F3_LW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return {4'b0000, m};
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational lane logic: store data shift/mask and load extract/extend.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic [7:0]            st_mask,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [DATA_WIDTH-1:0] ld_shift;

  // Store side: move data into its byte lane and build the strobe
  always_comb begin
    st_data = st_wdata << {addr_lo, 3'b000};
    st_mask = wmask_gen(funct3, addr_lo);
  end

  // Load side: bring the addressed bytes to bit 0, then sign/zero extend
  always_comb begin
    ld_shift = ld_rdata >> {addr_lo, 3'b000};
    ld_data  = '0;
    case (funct3)
      F3_LB:   ld_data = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_data = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
      F3_LW:   ld_data = ld_rdata;
      F3_LBU:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]};
      F3_LHU:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one request at a time from EXU, store strobe or
// variable-latency load toward MEM, response back to WBU.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_err;
  logic [DATA_WIDTH-1:0] st_data;
  logic [7:0]            st_mask;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [ADDR_WIDTH-1:0] addr_word;

  // Lane logic only ever sees latched fields, so mem_* never depends on req_*
  ysyx_23060201_lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .st_wdata (wdata_q),
    .st_data  (st_data),
    .st_mask  (st_mask),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  // State and latched request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state: accept in IDLE, one STORE cycle, wait in LOAD, hold RESP until taken
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    req_err  = is_illegal(req_we, req_funct3) | is_misaligned(req_funct3, req_addr[1:0]);
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err)     state_d = S_RESP;
          else if (req_we) state_d = S_STORE;
          else             state_d = S_LOAD;
        end
      end
      S_STORE: state_d = S_RESP;
      S_LOAD: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched fields; data buses forced to 0 when idle
  always_comb begin
    addr_word  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    req_ready  = (state_q == S_IDLE);
    mem_wen    = (state_q == S_STORE);
    mem_waddr  = mem_wen ? addr_word : '0;
    mem_wdata  = mem_wen ? st_data : '0;
    mem_wmask  = mem_wen ? st_mask : '0;
    mem_ren    = (state_q == S_LOAD);
    mem_raddr  = mem_ren ? addr_word : '0;
    resp_valid = (state_q == S_RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid & err_q;
  end

endmodule
